// File: rtl/my_viterbi_if.sv
// Serial receive-path bundle for the my_viterbi decoder.
// The master drives the coded bit stream (and the legacy pair-phase hint);
// the slave returns the decoded stream, its valid strobe, the corrected-error
// flag and the idle indication.
interface my_viterbi_if;
    logic x;         // hard-decision coded bit, one per clk
    logic clk_div2;  // legacy pair-phase hint, not used by the decoder
    logic y;         // decoded bit, valid while rd=1
    logic c;         // last frame needed correction
    logic rd;        // decoded-bit valid strobe
    logic ready;     // receiver idle, waiting for a frame start

    modport master (
        output x,
        output clk_div2,
        input  y,
        input  c,
        input  rd,
        input  ready
    );

    modport slave (
        input  x,
        input  clk_div2,
        output y,
        output c,
        output rd,
        output ready
    );
endinterface

// File: rtl/my_viterbi.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, generators 7 (g0) and 5 (g1).
// A frame is 14 coded bits (7 trellis steps), g0 then g1 per step. Survivors
// are kept by register exchange; after the last pair the best path is loaded
// into an output shift register and streamed out oldest bit first.
// Compile-time option: VITERBI_TAIL_EN -- frames are zero-terminated, so the
// final selection always takes state 0 instead of searching for the minimum.
module my_viterbi (
    input  logic        clk,
    input  logic        reset,   // asynchronous, active low
    my_viterbi_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECV   = 2'd1;
    localparam logic [1:0] ST_SELECT = 2'd2;

    localparam logic [3:0] LAST_BIT  = 4'd13;
    localparam logic [3:0] METRIC_MAX = 4'hF;

    logic [1:0] state_reg;
    logic [3:0] bit_cnt_reg;
    logic       even_bit_reg;
    logic       c_reg;

    // Path metrics and register-exchange survivors, indexed by state {s1,s2}
    logic [3:0] metric_reg [4];
    logic [6:0] path_reg   [4];
    logic [3:0] metric_next [4];
    logic [6:0] path_next   [4];

    // Output serializer
    logic [6:0] out_shift_reg;
    logic [2:0] out_cnt_reg;
    logic       y_reg;
    logic       rd_reg;

    // Final-state choice
    logic [1:0] best_idx_next;
    logic [3:0] best_metric_next;

    // Received pair: g0 bit was captured on the even edge, g1 is arriving now
    logic [1:0] rx_pair;
    assign rx_pair = {even_bit_reg, bus.x};

    // The pair phase comes from bit_cnt_reg; the legacy hint is deliberately ignored
    logic unused_clk_div2;
    assign unused_clk_div2 = bus.clk_div2;

    // One add-compare-select unit per next state {u, a}.
    // Its predecessors are {a,0} and {a,1}; the branch from {s1,s2} under input u
    // emits (u^s1^s2, u^s2), so the two candidate branches emit complementary pairs.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acs
            localparam logic [1:0] NS   = 2'(gi);
            localparam logic [1:0] P0   = {NS[0], 1'b0};
            localparam logic [1:0] P1   = {NS[0], 1'b1};
            localparam logic [1:0] EXP0 = {NS[1] ^ NS[0], NS[1]};
            localparam logic [1:0] EXP1 = EXP0 ^ 2'b11;

            logic [1:0] diff0, diff1;
            logic [1:0] bm0, bm1;
            logic [4:0] sum0, sum1;
            logic [3:0] sat0, sat1;
            logic       take1;

            assign diff0 = rx_pair ^ EXP0;
            assign diff1 = rx_pair ^ EXP1;
            assign bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
            assign bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};
            assign sum0  = {1'b0, metric_reg[P0]} + {3'b000, bm0};
            assign sum1  = {1'b0, metric_reg[P1]} + {3'b000, bm1};
            assign sat0  = sum0[4] ? METRIC_MAX : sum0[3:0];
            assign sat1  = sum1[4] ? METRIC_MAX : sum1[3:0];
            // Strictly smaller wins, so a tie keeps the s2=0 predecessor
            assign take1 = (sat1 < sat0);

            assign metric_next[gi] = take1 ? sat1 : sat0;
            assign path_next[gi]   = take1 ? {path_reg[P1][5:0], NS[1]}
                                           : {path_reg[P0][5:0], NS[1]};
        end
    endgenerate

    // Choose the terminal state whose survivor is emitted
    always_comb begin
        best_idx_next    = 2'd0;
        best_metric_next = metric_reg[0];
`ifdef VITERBI_TAIL_EN
        // Zero-terminated frames always end in state 0
        best_idx_next    = 2'd0;
        best_metric_next = metric_reg[0];
`else
        // Strict compare keeps the lowest index on ties
        for (int i = 1; i < 4; i++) begin
            if (metric_reg[i] < best_metric_next) begin
                best_metric_next = metric_reg[i];
                best_idx_next    = 2'(i);
            end
        end
`endif
    end

    // Receiver FSM: frame detection, bit capture, ACS updates and final select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 4'd0;
            even_bit_reg <= 1'b0;
            c_reg        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                metric_reg[i] <= 4'd0;
                path_reg[i]   <= 7'd0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Every frame opens with info bit 1, hence coded bit 0 is 1
                    if (bus.x) begin
                        even_bit_reg <= 1'b1;
                        bit_cnt_reg  <= 4'd1;
                        state_reg    <= ST_RECV;
                        for (int i = 0; i < 4; i++) begin
                            metric_reg[i] <= (i == 0) ? 4'd0 : METRIC_MAX;
                            path_reg[i]   <= 7'd0;
                        end
                    end
                end
                ST_RECV: begin
                    if (bit_cnt_reg[0]) begin
                        for (int i = 0; i < 4; i++) begin
                            metric_reg[i] <= metric_next[i];
                            path_reg[i]   <= path_next[i];
                        end
                    end else begin
                        even_bit_reg <= bus.x;
                    end
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_reg <= ST_SELECT;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end
                ST_SELECT: begin
                    c_reg       <= (best_metric_next != 4'd0);
                    bit_cnt_reg <= 4'd0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Output serializer: load the survivor on select, then shift out 7 bits MSB first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_shift_reg <= 7'd0;
            out_cnt_reg   <= 3'd0;
            y_reg         <= 1'b0;
            rd_reg        <= 1'b0;
        end else if (state_reg == ST_SELECT) begin
            out_shift_reg <= path_reg[best_idx_next];
            out_cnt_reg   <= 3'd7;
            y_reg         <= 1'b0;
            rd_reg        <= 1'b0;
        end else if (out_cnt_reg != 3'd0) begin
            y_reg         <= out_shift_reg[6];
            rd_reg        <= 1'b1;
            out_shift_reg <= {out_shift_reg[5:0], 1'b0};
            out_cnt_reg   <= out_cnt_reg - 3'd1;
        end else begin
            y_reg  <= 1'b0;
            rd_reg <= 1'b0;
        end
    end

    assign bus.y     = y_reg;
    assign bus.c     = c_reg;
    assign bus.rd    = rd_reg;
    assign bus.ready = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_my_viterbi.sv
// Directed bench for my_viterbi: reset/idle, clean and corrected frames,
// back-to-back frames, mid-frame abort and (with VITERBI_TAIL_EN) a
// tail-error frame. Expected streams are hand-encoded from info 1011000.
module tb_my_viterbi;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    // Decoded bits collected at the falling edge whenever rd is high
    logic [13:0] got_bits;
    int          got_cnt;

    logic [13:0] frame_clean;
    logic [13:0] frame_err1;
    logic [13:0] frame_tail2;

    my_viterbi_if bus_if ();

    my_viterbi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every valid decoded bit
    always @(negedge clk) begin
        if (bus_if.rd === 1'b1) begin
            got_bits = {got_bits[12:0], bus_if.y};
            got_cnt  = got_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send 14 coded bits MSB first; ready must drop on the edge sampling bit 0
    task automatic send_frame(input logic [13:0] f, input string tag);
        for (int i = 13; i >= 0; i--) begin
            bus_if.x        = f[i];
            bus_if.clk_div2 = ~bus_if.clk_div2;
            tick();
            if (i == 13) chk({tag, "_ready_drop"}, 32'(bus_if.ready), 32'd0);
        end
        bus_if.x = 1'b0;
    endtask

    task automatic clear_got();
        got_bits = 14'd0;
        got_cnt  = 0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        frame_clean = 14'b11100001011100;
        frame_err1  = 14'b11000001011100;
        frame_tail2 = 14'b11100001011111;
        bus_if.x        = 1'b0;
        bus_if.clk_div2 = 1'b0;
        clear_got();

        // Reset state
        reset = 1'b0;
        #12;
        chk("rst_ready", 32'(bus_if.ready), 32'd1);
        chk("rst_rd",    32'(bus_if.rd),    32'd0);
        chk("rst_y",     32'(bus_if.y),     32'd0);
        chk("rst_c",     32'(bus_if.c),     32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Idle with x=0: stays ready, no output
        for (int k = 0; k < 10; k++) tick();
        chk("idle_ready", 32'(bus_if.ready), 32'd1);
        chk("idle_no_rd", 32'(got_cnt),      32'd0);

        // Clean frame with latency checks
        clear_got();
        send_frame(frame_clean, "clean");
        chk("clean_ready_after_b13", 32'(bus_if.ready), 32'd0);
        tick();
        chk("clean_ready_back", 32'(bus_if.ready), 32'd1);
        chk("clean_rd_not_yet", 32'(bus_if.rd),    32'd0);
        tick();
        chk("clean_first_rd", 32'(bus_if.rd), 32'd1);
        chk("clean_first_y",  32'(bus_if.y),  32'd1);
        for (int k = 0; k < 7; k++) tick();
        chk("clean_cnt",   32'(got_cnt),       32'd7);
        chk("clean_bits",  32'(got_bits[6:0]), 32'h58);
        chk("clean_c",     32'(bus_if.c),      32'd0);
        chk("clean_rd_end", 32'(bus_if.rd),    32'd0);
        chk("clean_y_end",  32'(bus_if.y),     32'd0);

        // Single coded-bit error: corrected, c=1
        clear_got();
        send_frame(frame_err1, "err1");
        for (int k = 0; k < 10; k++) tick();
        chk("err1_cnt",  32'(got_cnt),       32'd7);
        chk("err1_bits", 32'(got_bits[6:0]), 32'h58);
        chk("err1_c",    32'(bus_if.c),      32'd1);

        // Mid-frame reset: abort with reset outputs, no partial output
        clear_got();
        for (int i = 13; i >= 8; i--) begin
            bus_if.x = frame_clean[i];
            tick();
        end
        bus_if.x = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(bus_if.ready), 32'd1);
        chk("abort_rd",    32'(bus_if.rd),    32'd0);
        chk("abort_y",     32'(bus_if.y),     32'd0);
        chk("abort_c",     32'(bus_if.c),     32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("abort_no_rd", 32'(got_cnt), 32'd0);
        send_frame(frame_clean, "post_abort");
        for (int k = 0; k < 10; k++) tick();
        chk("post_abort_cnt",  32'(got_cnt),       32'd7);
        chk("post_abort_bits", 32'(got_bits[6:0]), 32'h58);
        chk("post_abort_c",    32'(bus_if.c),      32'd0);

        // Back-to-back frames, second starts while first is still being emitted
        clear_got();
        send_frame(frame_clean, "b2b_a");
        for (int k = 0; k < 3; k++) tick();
        send_frame(frame_clean, "b2b_b");
        for (int k = 0; k < 12; k++) tick();
        chk("b2b_cnt",  32'(got_cnt),  32'd14);
        chk("b2b_bits", 32'(got_bits), 32'h2C58);
        chk("b2b_c",    32'(bus_if.c), 32'd0);

`ifdef VITERBI_TAIL_EN
        // Two errors in the final pair: terminated decode still takes state 0
        clear_got();
        send_frame(frame_tail2, "tail2");
        for (int k = 0; k < 10; k++) tick();
        chk("tail2_cnt",  32'(got_cnt),       32'd7);
        chk("tail2_bits", 32'(got_bits[6:0]), 32'h58);
        chk("tail2_c",    32'(bus_if.c),      32'd1);
`else
        frame_tail2 = 14'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
